msrv32_pipe_skid_reg: RTL and testbench
=======================================

Name: msrv32_pipe_skid_reg

Overview:
Parametrised successor to the fixed per-field pipeline stage registers. It is a single generic stage register that carries a packed payload of DATA_W bits. It adds a ready/valid handshake, a 2-entry skid buffer for back-pressure, flush with NOP injection (for branch-taken kill), and a saturating counter of discarded entries. One instance is placed between each pair of RV32I pipeline stages; the payload is the concatenation of that stage's fields.

Parameters:
DATA_W, 64, payload width in bits (1..512)
NOP_VALUE, {DATA_W{1'b0}}, payload driven on out_data_out after reset and after a flush when FLUSH_TO_NOP=1
FLUSH_TO_NOP, 1, 1: a flush loads NOP_VALUE into the output register; 0: the output payload holds its last value
CNT_W, 8, width of drop_count_out

Ports:
clk_in  input  1  clock; all state updates on the rising edge
reset_in  input  1  asynchronous, active-high reset
flush_in  input  1  synchronous kill of all held entries (branch_taken)
in_valid_in  input  1  upstream payload valid
in_ready_out  output  1  stage can accept; equals ~skid_valid, from a register only
in_data_in  input  DATA_W  upstream payload
out_valid_out  output  1  main register valid (registered)
out_ready_in  input  1  downstream accepts
out_data_out  output  DATA_W  main register payload (registered)
occupancy_out  output  2  number of valid entries, 0..2
drop_count_out  output  CNT_W  valid entries discarded by flushes, saturating

Behaviour:
- Reset (async assert, sync release):
  - out_valid_out=0, skid_valid=0, occupancy_out=0, drop_count_out=0.
  - out_data_out=NOP_VALUE; skid data=0.
  - in_ready_out=1.
- Accept event: in_valid_in & in_ready_out. Emit event: out_valid_out & out_ready_in.
- States are encoded by occupancy: EMPTY(0), ONE(1, main only), TWO(2, main+skid).
- EMPTY:
  - accept -> main<=in_data_in, go to ONE.
  - No emit is possible.
- ONE:
  - accept & emit -> main<=in_data_in, stay in ONE (full throughput, 1 transfer/cycle).
  - accept & ~emit -> skid<=in_data_in, go to TWO.
  - ~accept & emit -> go to EMPTY; main payload is held.
  - Neither -> hold.
- TWO:
  - in_ready_out=0, so no accept.
  - emit -> main<=skid, go to ONE.
  - Otherwise hold.
- Latency: 1 cycle from accept to out_valid_out when EMPTY, or when ONE with emit.
- Ordering is strictly FIFO; no payload is ever duplicated or dropped except by flush.
- in_ready_out has no combinational path from out_ready_in or in_valid_in.
- flush_in (highest priority over all of the above):
  - Next state is EMPTY.
  - Any accept in the same cycle is discarded.
  - The main payload becomes NOP_VALUE if FLUSH_TO_NOP=1, else it is held.
  - drop_count_out += (entries valid before the edge, minus 1 if an emit occurred that cycle).
  - An emit in a flush cycle is a completed transfer; downstream receives the same flush and handles its own kill.
  - The counter saturates at 2^CNT_W-1; it does not wrap.
- flush_in during reset has no effect.
- Reset asserted mid-transfer discards everything immediately, regardless of clock.
- Payload bits are transported unmodified; there is no width conversion.

Test Plan:
- Reset then stream: out_ready_in=1, in_valid_in=1, data 0x1,0x2,0x3 on consecutive cycles -> out_data_out 0x1,0x2,0x3 on cycles 1,2,3 with out_valid_out=1; occupancy_out=1 throughout; in_ready_out stays 1.
- Back-pressure: stream 0xA,0xB,0xC with out_ready_in=0 from cycle 1 -> out_data_out=0xA, occupancy_out=2, in_ready_out=0 after 0xB; 0xC is held upstream. Raise out_ready_in -> outputs 0xA,0xB,0xC in order, no loss.
- Flush at occupancy 2, out_ready_in=0, FLUSH_TO_NOP=1, NOP_VALUE=0x13 -> next cycle out_valid_out=0, out_data_out=0x13, occupancy_out=0, drop_count_out=2, in_ready_out=1.
- Flush coincident with accept and emit at occupancy 1 -> the accepted payload is discarded; drop_count_out is unchanged (0 dropped); state is EMPTY.
- Saturation: CNT_W=2, four flushes each dropping 2 entries -> drop_count_out reads 2, 3, 3, 3.
- Async reset pulse mid-stream between clock edges -> out_valid_out=0, out_data_out=NOP_VALUE, drop_count_out=0 immediately, without a clock edge.

Source files
------------

// File: rtl/msrv32_pipe_skid_reg.sv
// Generic RV32I pipeline stage register: ready/valid handshake, 2-entry skid buffer,
// flush with optional NOP injection and a saturating count of flushed entries.
module msrv32_pipe_skid_reg #(
    parameter int unsigned          DATA_W       = 64,
    parameter logic [DATA_W-1:0]    NOP_VALUE    = '0,
    parameter bit                   FLUSH_TO_NOP = 1'b1,
    parameter int unsigned          CNT_W        = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              flush_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    input  logic [DATA_W-1:0] in_data_in,
    output logic              out_valid_out,
    input  logic              out_ready_in,
    output logic [DATA_W-1:0] out_data_out,
    output logic [1:0]        occupancy_out,
    output logic [CNT_W-1:0]  drop_count_out
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_accept;
    logic                w_emit;
    logic [1:0]          w_occ;
    logic [1:0]          w_drop;
    logic [CNT_W+1:0]    w_cnt_sum;
    logic [CNT_W-1:0]    w_cnt_sat;

    assign w_accept = in_valid_in & r_in_ready;
    assign w_emit   = r_out_valid & out_ready_in;
    assign w_occ    = r_state;

    // An entry emitted in the flush cycle was delivered, so it is not counted as dropped.
    assign w_drop    = w_occ - {1'b0, w_emit};
    assign w_cnt_sum = {2'b00, r_drop_cnt} + {{CNT_W{1'b0}}, w_drop};
    assign w_cnt_sat = (w_cnt_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= NOP_VALUE;
            r_skid      <= '0;
            r_drop_cnt  <= '0;
        end else if (flush_in) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_drop_cnt  <= w_cnt_sat;
            if (FLUSH_TO_NOP) begin
                r_main <= NOP_VALUE;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data_in;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_emit) begin
                        r_main <= in_data_in;
                    end else if (w_accept) begin
                        r_skid     <= in_data_in;
                        r_state    <= S_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_emit) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (w_emit) begin
                        r_main     <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_out   = r_in_ready;
    assign out_valid_out  = r_out_valid;
    assign out_data_out   = r_main;
    assign occupancy_out  = w_occ;
    assign drop_count_out = r_drop_cnt;

endmodule

// File: tb/tb_msrv32_pipe_skid_reg.sv
// Bench for msrv32_pipe_skid_reg: directed handshake/flush/saturation/reset steps plus
// random traffic, all checked against a queue-based reference model.
module tb_msrv32_pipe_skid_reg;

    localparam int unsigned DW  = 16;
    localparam logic [DW-1:0] NOP = 16'h0013;
    localparam int CMAX = 3;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          flush_in;
    logic          in_valid_in;
    logic          in_ready_out;
    logic [DW-1:0] in_data_in;
    logic          out_valid_out;
    logic          out_ready_in;
    logic [DW-1:0] out_data_out;
    logic [1:0]    occupancy_out;
    logic [1:0]    drop_count_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last;
    int            m_cnt;

    msrv32_pipe_skid_reg #(
        .DATA_W      (DW),
        .NOP_VALUE   (NOP),
        .FLUSH_TO_NOP(1'b1),
        .CNT_W       (2)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .flush_in      (flush_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .in_data_in    (in_data_in),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .out_data_out  (out_data_out),
        .occupancy_out (occupancy_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last = NOP;
        m_cnt  = 0;
    endtask

    task automatic check_model(input string where);
        chk({where, "_valid"}, {31'd0, out_valid_out}, {31'd0, mq.size() > 0});
        chk({where, "_data"}, {16'd0, out_data_out}, {16'd0, (mq.size() > 0) ? mq[0] : m_last});
        chk({where, "_ready"}, {31'd0, in_ready_out}, {31'd0, mq.size() < 2});
        chk({where, "_occ"}, {30'd0, occupancy_out}, 32'(mq.size()));
        chk({where, "_drop"}, {30'd0, drop_count_out}, 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, then advance the model.
    task automatic cycle(input logic f, input logic iv, input logic [DW-1:0] id, input logic ordy);
        bit emit, accept;
        int drop;
        flush_in     = f;
        in_valid_in  = iv;
        in_data_in   = id;
        out_ready_in = ordy;
        @(negedge clk_in);
        check_model("cyc");
        emit   = (mq.size() > 0) && ordy;
        accept = iv && (mq.size() < 2);
        @(posedge clk_in);
        #1;
        if (f) begin
            drop  = mq.size() - (emit ? 1 : 0);
            m_cnt = (m_cnt + drop > CMAX) ? CMAX : m_cnt + drop;
            mq.delete();
            m_last = NOP;
        end else begin
            if (emit) m_last = mq.pop_front();
            if (accept) mq.push_back(id);
        end
    endtask

    task automatic do_reset();
        reset_in     = 1'b1;
        flush_in     = 1'b1;
        in_valid_in  = 1'b1;
        in_data_in   = 16'hdead;
        out_ready_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        flush_in = 1'b0;
        in_valid_in = 1'b0;
        model_reset();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", {31'd0, out_valid_out}, 32'd0);
        chk("rst_data", {16'd0, out_data_out}, 32'h13);
        chk("rst_ready", {31'd0, in_ready_out}, 32'd1);
        chk("rst_occ", {30'd0, occupancy_out}, 32'd0);
        chk("rst_drop", {30'd0, drop_count_out}, 32'd0);

        // Full-throughput stream
        cycle(0, 1, 16'h1, 1);
        chk("str_d1", {16'd0, out_data_out}, 32'h1);
        cycle(0, 1, 16'h2, 1);
        chk("str_d2", {16'd0, out_data_out}, 32'h2);
        cycle(0, 1, 16'h3, 1);
        chk("str_d3", {16'd0, out_data_out}, 32'h3);
        chk("str_occ", {30'd0, occupancy_out}, 32'd1);
        chk("str_ready", {31'd0, in_ready_out}, 32'd1);
        cycle(0, 0, 16'h0, 1);
        chk("str_empty", {30'd0, occupancy_out}, 32'd0);

        // Back-pressure into the skid entry, then drain in order
        do_reset();
        cycle(0, 1, 16'hA, 0);
        cycle(0, 1, 16'hB, 0);
        chk("bp_data", {16'd0, out_data_out}, 32'hA);
        chk("bp_occ", {30'd0, occupancy_out}, 32'd2);
        chk("bp_ready", {31'd0, in_ready_out}, 32'd0);
        cycle(0, 1, 16'hC, 0);
        chk("bp_hold", {16'd0, out_data_out}, 32'hA);
        cycle(0, 1, 16'hC, 1);
        chk("bp_out_b", {16'd0, out_data_out}, 32'hB);
        cycle(0, 1, 16'hC, 1);
        chk("bp_out_c", {16'd0, out_data_out}, 32'hC);
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 1);

        // Flush at occupancy 2 with downstream stalled
        do_reset();
        cycle(0, 1, 16'hA, 0);
        cycle(0, 1, 16'hB, 0);
        cycle(1, 0, 16'h0, 0);
        chk("fl2_valid", {31'd0, out_valid_out}, 32'd0);
        chk("fl2_data", {16'd0, out_data_out}, 32'h13);
        chk("fl2_occ", {30'd0, occupancy_out}, 32'd0);
        chk("fl2_drop", {30'd0, drop_count_out}, 32'd2);
        chk("fl2_ready", {31'd0, in_ready_out}, 32'd1);

        // Flush coincident with accept and emit at occupancy 1
        do_reset();
        cycle(0, 1, 16'h5, 0);
        cycle(1, 1, 16'h6, 1);
        chk("fl1_drop", {30'd0, drop_count_out}, 32'd0);
        chk("fl1_occ", {30'd0, occupancy_out}, 32'd0);
        chk("fl1_valid", {31'd0, out_valid_out}, 32'd0);
        cycle(0, 0, 16'h0, 1);

        // Counter saturation with a 2-bit counter
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 16'(k * 2 + 1), 0);
            cycle(0, 1, 16'(k * 2 + 2), 0);
            cycle(1, 0, 16'h0, 0);
            chk("sat_drop", {30'd0, drop_count_out}, (k == 0) ? 32'd2 : 32'd3);
        end

        // Asynchronous reset between clock edges
        cycle(0, 1, 16'h7, 0);
        cycle(0, 1, 16'h8, 0);
        #1 reset_in = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid_out}, 32'd0);
        chk("arst_data", {16'd0, out_data_out}, 32'h13);
        chk("arst_drop", {30'd0, drop_count_out}, 32'd0);
        chk("arst_occ", {30'd0, occupancy_out}, 32'd0);
        chk("arst_ready", {31'd0, in_ready_out}, 32'd1);
        #1 reset_in = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                  16'($urandom), $urandom_range(0, 3) != 0);
        end
        cycle(0, 0, 16'h0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
